gpu_framebuffer_ram: RTL and testbench



---
 rtl/gpu_framebuffer_ram.sv | 137 +++++++++++++
 tb/tb_gpu_framebuffer_ram.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_framebuffer_ram.sv
// 1-bpp bit-addressed framebuffer: pipelined read-modify-write op port plus a word-wide video read port.
// Op read data lands two cycles after issue, video data one cycle after grant; the op port never stalls.
module gpu_framebuffer_ram #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  ram_x,
   input  logic [7:0]  ram_y,
   input  logic        op_ram_enable_read,
   input  logic        op_ram_enable_write,
   input  logic        op_ram_write_value,
   output logic        op_ram_value,
   input  logic        vid_req,
   input  logic [11:0] vid_addr,
   output logic        vid_valid,
   output logic [15:0] vid_data,
   output logic        oob_error,
   output logic        conflict_error
);
   localparam int WORDS_PER_LINE = WIDTH / 16;
   localparam int DEPTH          = WORDS_PER_LINE * HEIGHT;

   logic [15:0] mem [DEPTH];
   logic [15:0] rdata;
   logic [11:0] op_word;
   logic [11:0] rd_addr;
   logic        op_in_range;
   logic        vid_in_range;
   logic        op_any;
   logic        do_wr;
   logic        do_rd;
   logic        vid_grant;

   logic        s1_vld;
   logic        r1_vld;
   logic        v1_vld;
   logic        p1_oob;
   logic [11:0] p1_addr;
   logic [3:0]  p1_bit;
   logic        p1_val;
   logic [15:0] fwd_word;
   logic [15:0] merged;
   logic        commit;

   logic        lw_vld;
   logic [11:0] lw_addr;
   logic [15:0] lw_data;

   assign op_word      = 12'(ram_y) * 12'(WORDS_PER_LINE) + 12'(ram_x[8:4]);
   assign op_in_range  = (int'(ram_x) < WIDTH) && (int'(ram_y) < HEIGHT);
   assign vid_in_range = int'(vid_addr) < DEPTH;
   assign op_any       = op_ram_enable_read || op_ram_enable_write;
   assign do_wr        = op_ram_enable_write && op_in_range;
   assign do_rd        = op_ram_enable_read && !op_ram_enable_write;
   // A delivered word blocks re-grant so a level request held through vid_valid is served once.
   assign vid_grant    = vid_req && !op_any && !v1_vld;

   always_comb begin
      rd_addr = '0;
      if (op_any) begin
         if (op_in_range) rd_addr = op_word;
      end else if (vid_grant && vid_in_range) begin
         rd_addr = vid_addr;
      end
   end

   always_ff @(posedge clk) begin
      rdata <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (commit) mem[p1_addr] <= merged;
   end

   // Stage-1 payload is shared: at most one of write, op read or video read is in flight.
   always_ff @(posedge clk) begin
      p1_addr <= rd_addr;
      p1_bit  <= ram_x[3:0];
      p1_val  <= op_ram_write_value;
      p1_oob  <= op_any ? !op_in_range : !vid_in_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         r1_vld <= 1'b0;
         v1_vld <= 1'b0;
      end else begin
         s1_vld <= do_wr;
         r1_vld <= do_rd;
         v1_vld <= vid_grant;
      end
   end

   // The array is read-first, so the word committed last cycle must be bypassed.
   assign fwd_word = (lw_vld && (lw_addr == p1_addr)) ? lw_data : rdata;
   assign commit   = s1_vld && !rst;

   always_comb begin
      merged         = fwd_word;
      merged[p1_bit] = p1_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lw_vld <= 1'b0;
      end else if (commit) begin
         lw_vld  <= 1'b1;
         lw_addr <= p1_addr;
         lw_data <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_ram_value <= 1'b0;
      end else if (r1_vld) begin
         op_ram_value <= p1_oob ? 1'b0 : fwd_word[p1_bit];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oob_error      <= 1'b0;
         conflict_error <= 1'b0;
      end else begin
         if (op_any && !op_in_range) oob_error <= 1'b1;
         if (op_ram_enable_read && op_ram_enable_write) conflict_error <= 1'b1;
      end
   end

   assign vid_valid = v1_vld;
   assign vid_data  = (v1_vld && !p1_oob) ? fwd_word : 16'h0000;

endmodule

// File: tb/tb_gpu_framebuffer_ram.sv
// Directed and randomized bench for gpu_framebuffer_ram against a pixel-level reference model.
module tb_gpu_framebuffer_ram;
   localparam int WIDTH  = 320;
   localparam int HEIGHT = 200;
   localparam int WPL    = WIDTH / 16;
   localparam int DEPTH  = WPL * HEIGHT;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  ram_x;
   logic [7:0]  ram_y;
   logic        op_ram_enable_read;
   logic        op_ram_enable_write;
   logic        op_ram_write_value;
   logic        op_ram_value;
   logic        vid_req;
   logic [11:0] vid_addr;
   logic        vid_valid;
   logic [15:0] vid_data;
   logic        oob_error;
   logic        conflict_error;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural model: every accepted write is visible to any later-issued access.
   logic [15:0] mdl [DEPTH];
   logic        exp_opv, exp_oob, exp_conf, exp_vv;
   logic [15:0] exp_vd;
   logic        rd_pend, rd_pend_val;
   logic        pw_vld;
   int          pw_addr;
   logic [15:0] pw_old;

   always #5 clk = ~clk;

   gpu_framebuffer_ram #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ram_x               (ram_x),
      .ram_y               (ram_y),
      .op_ram_enable_read  (op_ram_enable_read),
      .op_ram_enable_write (op_ram_enable_write),
      .op_ram_write_value  (op_ram_write_value),
      .op_ram_value        (op_ram_value),
      .vid_req             (vid_req),
      .vid_addr            (vid_addr),
      .vid_valid           (vid_valid),
      .vid_data            (vid_data),
      .oob_error           (oob_error),
      .conflict_error      (conflict_error)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, then compare all outputs.
   task automatic cyc(input logic rs, input logic r, input logic w, input int x, input int y,
                      input logic v, input logic vr, input int va);
      bit          inr;
      int          wa;
      int          b;
      logic        nx_opv, nx_oob, nx_conf, nx_vv;
      logic [15:0] nx_vd;
      rst                 = rs;
      op_ram_enable_read  = r;
      op_ram_enable_write = w;
      ram_x               = 9'(x);
      ram_y               = 8'(y);
      op_ram_write_value  = v;
      vid_req             = vr;
      vid_addr            = 12'(va);
      inr     = (x < WIDTH) && (y < HEIGHT);
      wa      = y * WPL + x / 16;
      b       = x % 16;
      nx_opv  = rd_pend ? rd_pend_val : exp_opv;
      nx_oob  = exp_oob;
      nx_conf = exp_conf;
      nx_vv   = 1'b0;
      nx_vd   = 16'h0000;
      rd_pend = 1'b0;
      if (rs) begin
         if (pw_vld) mdl[pw_addr] = pw_old;
         pw_vld  = 1'b0;
         nx_opv  = 1'b0;
         nx_oob  = 1'b0;
         nx_conf = 1'b0;
      end else begin
         pw_vld = 1'b0;
         if ((r || w) && !inr) nx_oob = 1'b1;
         if (r && w) nx_conf = 1'b1;
         if (w && inr) begin
            pw_old     = mdl[wa];
            pw_addr    = wa;
            pw_vld     = 1'b1;
            mdl[wa][b] = v;
         end
         if (r && !w) begin
            rd_pend     = 1'b1;
            rd_pend_val = inr ? mdl[wa][b] : 1'b0;
         end
         if (vr && !r && !w) begin
            nx_vv = 1'b1;
            nx_vd = (va < DEPTH) ? mdl[va] : 16'h0000;
         end
      end
      @(posedge clk);
      #1;
      exp_opv  = nx_opv;
      exp_oob  = nx_oob;
      exp_conf = nx_conf;
      exp_vv   = nx_vv;
      exp_vd   = nx_vd;
      check("op_ram_value", 16'(op_ram_value), 16'(exp_opv));
      check("vid_valid", 16'(vid_valid), 16'(exp_vv));
      if (exp_vv) check("vid_data", vid_data, exp_vd);
      check("oob_error", 16'(oob_error), 16'(exp_oob));
      check("conflict_error", 16'(conflict_error), 16'(exp_conf));
   endtask

   task automatic wr(input int x, input int y, input logic v);
      cyc(1'b0, 1'b0, 1'b1, x, y, v, 1'b0, 0);
   endtask

   task automatic rd(input int x, input int y);
      cyc(1'b0, 1'b1, 1'b0, x, y, 1'b0, 1'b0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic reset_cyc();
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic vid_read(input string tag, input int a, input logic [15:0] lit);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, a);
         if (vid_valid === 1'b1) begin
            got = 1'b1;
            check(tag, vid_data, lit);
         end
      end
      check({tag, "_served"}, 16'(got), 16'h0001);
      idle(1);
   endtask

   initial begin
      int          cnt;
      logic [15:0] snap;
      logic        req_on;
      int          req_a;
      rst = 1'b1; ram_x = '0; ram_y = '0;
      op_ram_enable_read = 1'b0; op_ram_enable_write = 1'b0; op_ram_write_value = 1'b0;
      vid_req = 1'b0; vid_addr = '0;
      exp_opv = 1'b0; exp_oob = 1'b0; exp_conf = 1'b0; exp_vv = 1'b0; exp_vd = '0;
      rd_pend = 1'b0; rd_pend_val = 1'b0; pw_vld = 1'b0; pw_addr = 0; pw_old = '0;

      repeat (3) reset_cyc();
      check("rst_op_ram_value", 16'(op_ram_value), 16'h0000);
      check("rst_vid_valid", 16'(vid_valid), 16'h0000);
      check("rst_vid_data", vid_data, 16'h0000);
      check("rst_oob_error", 16'(oob_error), 16'h0000);
      check("rst_conflict_error", 16'(conflict_error), 16'h0000);

      // Clear rows 0..7 back-to-back, which also exercises same-word bypassing.
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < WIDTH; x++) wr(x, y, 1'b0);

      wr(0, 0, 1'b1);
      rd(0, 0);
      idle(1);
      check("rd_0_0", 16'(op_ram_value), 16'h0001);
      vid_read("vid_word0", 0, 16'h0001);

      for (int x = 0; x < 32; x++) wr(x, 3, 1'b1);
      vid_read("vid_word60", 60, 16'hFFFF);
      vid_read("vid_word61", 61, 16'hFFFF);
      vid_read("vid_word62", 62, 16'h0000);

      wr(17, 0, 1'b1);
      rd(17, 0);
      idle(1);
      check("fwd_rd_17_set", 16'(op_ram_value), 16'h0001);
      wr(17, 0, 1'b0);
      rd(17, 0);
      idle(1);
      check("fwd_rd_17_clr", 16'(op_ram_value), 16'h0000);

      wr(80, 0, 1'b1);
      wr(95, 0, 1'b1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, (i % 2) == 0, 1'b0, 17, 0, 1'b0, 1'b1, 5);
         if (vid_valid === 1'b1) begin
            cnt++;
            check("vid_toggle_data", vid_data, 16'h8001);
         end
      end
      idle(1);
      if (vid_valid === 1'b1) cnt++;
      check("vid_toggle_count", 16'(cnt), 16'h0004);

      req_on = 1'b0;
      req_a  = 0;
      for (int i = 0; i < 1500; i++) begin
         int   k;
         int   rx;
         int   ry;
         logic rr;
         logic ww;
         k  = $urandom_range(0, 9);
         rr = (k < 3) || (k == 6);
         ww = (k >= 3) && (k < 7);
         rx = $urandom_range(0, WIDTH + 15);
         ry = ($urandom_range(0, 15) == 0) ? $urandom_range(HEIGHT, 255) : $urandom_range(0, 7);
         if (exp_vv) begin
            req_on = 1'b0;
         end else if (!req_on && $urandom_range(0, 3) == 0) begin
            req_on = 1'b1;
            req_a  = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, 159);
         end
         cyc(1'b0, rr, ww, rx, ry, 1'($urandom_range(0, 1)), req_on, req_a);
      end
      idle(2);

      reset_cyc();
      reset_cyc();
      check("oob_cleared", 16'(oob_error), 16'h0000);
      wr(0, 0, 1'b1);
      rd(0, 0);
      idle(1);
      check("rd_before_oob", 16'(op_ram_value), 16'h0001);
      snap = mdl[20];
      wr(320, 0, 1'b1);
      idle(1);
      check("oob_after_wr", 16'(oob_error), 16'h0001);
      rd(0, 200);
      idle(1);
      check("oob_rd_value", 16'(op_ram_value), 16'h0000);
      vid_read("oob_wr_dropped", 20, snap);
      vid_read("vid_oob_addr", 4000, 16'h0000);
      idle(5);
      check("oob_sticky", 16'(oob_error), 16'h0001);
      reset_cyc();
      check("oob_rst", 16'(oob_error), 16'h0000);

      wr(4, 4, 1'b0);
      wr(5, 4, 1'b0);
      wr(0, 0, 1'b1);
      rd(0, 0);
      idle(1);
      check("rd_before_conflict", 16'(op_ram_value), 16'h0001);
      cyc(1'b0, 1'b1, 1'b1, 4, 4, 1'b1, 1'b0, 0);
      idle(2);
      check("conflict_op_hold", 16'(op_ram_value), 16'h0001);
      check("conflict_flag", 16'(conflict_error), 16'h0001);
      rd(5, 4);
      idle(1);
      check("rd_5_4", 16'(op_ram_value), 16'h0000);
      rd(4, 4);
      idle(1);
      check("conflict_wr_done", 16'(op_ram_value), 16'h0001);

      wr(5, 5, 1'b0);
      idle(2);
      wr(5, 5, 1'b1);
      reset_cyc();
      check("conflict_rst", 16'(conflict_error), 16'h0000);
      idle(1);
      rd(5, 5);
      idle(1);
      check("rst_drops_s1_wr", 16'(op_ram_value), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
